// File: rtl/payload_arb_pkg.sv
// payload_arb_pkg: shared definitions for the payload FIFO arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE/GRANT/XFER/GAP)
//   clog2()     : ceiling log2 used for counter widths
//   eop_bit()   : position of the end-of-packet flag in a FIFO word
package payload_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int eop_bit(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin picker.
//   req   : request vector, one bit per port
//   ptr   : highest-priority port this round
//   idx   : first requesting port at or after ptr (wrapping)
//   found : at least one request is set
module rr_priority_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [PORT_W-1:0]    idx,
  output logic                 found
);

  // Walk NUM_PORTS positions starting at ptr; wrap is an explicit
  // subtract so non-power-of-two port counts stay correct.
  always_comb begin
    int p;
    found = 1'b0;
    idx   = '0;
    p     = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      p = int'(ptr) + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!found && req[p[PORT_W-1:0]]) begin
        found = 1'b1;
        idx   = p[PORT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/payload_fifo_arbiter.sv
// payload_fifo_arbiter: packet-level round-robin arbiter sharing one egress
// datapath among NUM_PORTS first-word-fall-through payload FIFOs.
//   pos_rclk, aresetn_rclk (async, low), sresetn_rclk (sync, low)
//   fifo_dvld / fifo_dout  : per-port FWFT head valid / head word (EOP in MSB)
//   fifo_rd_en             : per-port pop, at most one bit high
//   out_data/out_eop/out_valid/out_ready : egress stream
//   out_port               : source port of the current packet
//   busy                   : FSM not in IDLE
//   err_overlen            : one-cycle pulse, registered, in the cycle after
//                            the beat a packet was truncated at MAX_WORDS
module payload_fifo_arbiter
  import payload_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 9,
  parameter int IFG_CYCLES = 2,
  parameter int MAX_WORDS  = 1536,
  parameter int PORT_W     = 2
) (
  input  logic                            pos_rclk,
  input  logic                            aresetn_rclk,
  input  logic                            sresetn_rclk,
  input  logic [NUM_PORTS-1:0]            fifo_dvld,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_dout,
  output logic [NUM_PORTS-1:0]            fifo_rd_en,
  output logic [DATA_WIDTH-2:0]           out_data,
  output logic                            out_eop,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PORT_W-1:0]               out_port,
  output logic                            busy,
  output logic                            err_overlen
);

  localparam int EOP_BIT = eop_bit(DATA_WIDTH);
  localparam int CNT_W   = clog2(MAX_WORDS + 1);
  localparam int GAP_W   = (IFG_CYCLES > 0) ? clog2(IFG_CYCLES + 1) : 1;

  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] dout_a;
  arb_state_e                           state;
  logic [PORT_W-1:0]                    rr_ptr, pick_idx, next_ptr;
  logic                                 pick_found;
  logic [CNT_W-1:0]                     word_cnt;
  logic [GAP_W-1:0]                     gap_cnt;
  logic [DATA_WIDTH-1:0]                head;
  logic                                 xfer, beat, at_limit, trunc, last_beat;

  assign dout_a = fifo_dout;
  assign head   = dout_a[out_port];

  // Egress is combinational from the granted port while in XFER. The sync
  // reset also masks it so a word is never popped in the cycle it resets.
  assign xfer      = (state == XFER) && sresetn_rclk;
  assign out_valid = xfer & fifo_dvld[out_port];
  assign out_data  = xfer ? head[DATA_WIDTH-2:0] : '0;
  assign at_limit  = (word_cnt >= CNT_W'(MAX_WORDS - 1));
  assign out_eop   = out_valid & (head[EOP_BIT] | at_limit);
  assign beat      = out_valid & out_ready;
  assign trunc     = beat & ~head[EOP_BIT] & at_limit;
  assign last_beat = beat & out_eop;
  assign next_ptr  = (out_port == PORT_W'(NUM_PORTS - 1)) ? '0 : out_port + 1'b1;
  assign busy      = (state != IDLE);

  always_comb begin
    fifo_rd_en = '0;
    if (beat) fifo_rd_en[out_port] = 1'b1;
  end

  rr_priority_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_pick (
    .req   (fifo_dvld),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      out_port    <= '0;
      word_cnt    <= '0;
      gap_cnt     <= '0;
      err_overlen <= 1'b0;
    end else if (!sresetn_rclk) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      out_port    <= '0;
      word_cnt    <= '0;
      gap_cnt     <= '0;
      err_overlen <= 1'b0;
    end else begin
      err_overlen <= 1'b0;
      case (state)
        IDLE: if (|fifo_dvld) state <= GRANT;
        GRANT: begin
          // Requests can vanish between IDLE and GRANT; fall back if so.
          if (pick_found) begin
            out_port <= pick_idx;
            word_cnt <= '0;
            state    <= XFER;
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          if (beat && word_cnt != CNT_W'(MAX_WORDS))
            word_cnt <= word_cnt + 1'b1;
          // Truncation exits like a real EOP; the rest of the packet stays
          // queued and competes again as a new packet.
          if (last_beat) begin
            rr_ptr      <= next_ptr;
            err_overlen <= trunc;
            gap_cnt     <= '0;
            state       <= (IFG_CYCLES == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (int'(gap_cnt) >= IFG_CYCLES - 1) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_payload_fifo_arbiter.sv
// tb_payload_fifo_arbiter: self-checking bench for payload_fifo_arbiter.
// Per-port FWFT FIFOs are modelled as arrays with read/write pointers; every
// word loaded with tracking pushes its expected egress beat to a scoreboard
// that a negedge monitor pops and compares.
module tb_payload_fifo_arbiter;

  localparam int NP = 4;
  localparam int DW = 9;

  typedef struct {
    logic [1:0] port;
    logic [7:0] data;
    logic       eop;
  } exp_t;

  logic              pos_rclk = 1'b0;
  logic              aresetn_rclk = 1'b0;
  logic              sresetn_rclk = 1'b1;
  logic [NP-1:0]     fifo_dvld;
  logic [NP*DW-1:0]  fifo_dout;
  logic [NP-1:0]     fifo_rd_en;
  logic [DW-2:0]     out_data;
  logic              out_eop, out_valid, busy, err_overlen;
  logic              out_ready = 1'b1;
  logic [1:0]        out_port;

  logic [DW-1:0]     mem [NP][32];
  logic [4:0]        wrp [NP] = '{default: '0};
  logic [4:0]        rdp [NP] = '{default: '0};
  logic [NP-1:0]     mask = '0;

  exp_t              sb[$];
  int                beat_cyc[$];
  int                n_chk = 0, n_pass = 0;
  int                n_beats = 0, err_cnt = 0, rd_pulses = 0, cyc = 0;

  payload_fifo_arbiter #(
    .NUM_PORTS (NP), .DATA_WIDTH (DW), .IFG_CYCLES (2),
    .MAX_WORDS (4),  .PORT_W (2)
  ) dut (
    .pos_rclk     (pos_rclk),
    .aresetn_rclk (aresetn_rclk),
    .sresetn_rclk (sresetn_rclk),
    .fifo_dvld    (fifo_dvld),
    .fifo_dout    (fifo_dout),
    .fifo_rd_en   (fifo_rd_en),
    .out_data     (out_data),
    .out_eop      (out_eop),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_port     (out_port),
    .busy         (busy),
    .err_overlen  (err_overlen)
  );

  always #5 pos_rclk = ~pos_rclk;
  always @(posedge pos_rclk) cyc++;

  for (genvar i = 0; i < NP; i++) begin : g_fifo
    assign fifo_dvld[i]          = (rdp[i] != wrp[i]) && !mask[i];
    assign fifo_dout[i*DW +: DW] = mem[i][rdp[i]];
  end

  always @(posedge pos_rclk)
    for (int i = 0; i < NP; i++)
      if (fifo_rd_en[i]) rdp[i] <= rdp[i] + 5'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge pos_rclk) begin
    exp_t e;
    logic [3:0] m;
    if (err_overlen) err_cnt++;
    rd_pulses += $countones(fifo_rd_en);
    if (out_valid && out_ready) begin
      n_beats++;
      beat_cyc.push_back(cyc);
      if (sb.size() == 0) chk("unexpected_beat", {24'd0, out_data}, 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        m = 4'b0001 << e.port;
        chk("beat_port", out_port, e.port);
        chk("beat_data", out_data, e.data);
        chk("beat_eop", out_eop, e.eop);
        chk("beat_rd_en", fifo_rd_en, m);
      end
    end else begin
      chk("idle_rd_en", fifo_rd_en, 0);
    end
  end

  task automatic tick();
    @(posedge pos_rclk);
    #2;
  endtask

  task automatic push_exp(input int port, input logic [7:0] d, input logic eop);
    exp_t e;
    e.port = port[1:0]; e.data = d; e.eop = eop;
    sb.push_back(e);
  endtask

  // Load one word into a port FIFO and optionally expect it on egress.
  task automatic put(input int port, input logic [7:0] d, input logic eop,
                     input logic exp_eop, input bit track);
    mem[port][wrp[port]] = {eop, d};
    wrp[port] = wrp[port] + 5'd1;
    if (track) push_exp(port, d, exp_eop);
  endtask

  task automatic wait_beats(input int n);
    for (int t = 0; t < 500 && n_beats < n; t++) tick();
    if (n_beats < n) chk("timeout_beats", n_beats, n);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 1000 && (sb.size() != 0 || busy); t++) tick();
    chk("drain_sb", sb.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  task automatic sync_reset();
    tick(); sresetn_rclk = 1'b0;
    tick(); sresetn_rclk = 1'b1;
  endtask

  initial begin
    logic [7:0] vv, bv;
    logic       uv, ub;
    int         pbad, base, pc0, e0, nb;

    // Reset state
    repeat (3) @(posedge pos_rclk);
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_overlen, 0);
    chk("rst_port", out_port, 0);
    aresetn_rclk = 1'b1;
    tick();

    // Single 3-word packet on port 2: valid 2 cycles after dvld, 2-cycle gap
    put(2, 8'hA0, 0, 0, 1);
    put(2, 8'hA1, 0, 0, 1);
    put(2, 8'hA2, 1, 1, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge pos_rclk);
      vv[k] = out_valid;
      bv[k] = busy;
    end
    chk("single_valid_trace", vv, 8'b0001_1100);
    chk("single_busy_trace", bv, 8'b0111_1110);
    wait_idle();

    // Round robin: grant order 0,1,2,3,0, 4 idle cycles between beats
    sync_reset();
    base = beat_cyc.size();
    put(0, 8'h01, 1, 1, 1);
    put(1, 8'h02, 1, 1, 1);
    put(2, 8'h03, 1, 1, 1);
    put(3, 8'h04, 1, 1, 1);
    put(0, 8'h05, 1, 1, 1);
    wait_idle();
    if (beat_cyc.size() >= base + 5)
      for (int k = 0; k < 4; k++)
        chk("rr_spacing", beat_cyc[base+k+1] - beat_cyc[base+k], 5);
    else chk("rr_beats", beat_cyc.size() - base, 5);

    // Backpressure: ready 1,0,0,1 over a 2-word packet
    sync_reset();
    pc0 = rd_pulses;
    put(3, 8'h10, 0, 0, 1);
    put(3, 8'h11, 1, 1, 1);
    for (int t = 0; t < 50 && !out_valid; t++) tick();
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    @(negedge pos_rclk);
    chk("bp_hold_data0", out_data, 8'h11);
    chk("bp_hold_rd0", fifo_rd_en, 0);
    tick();
    @(negedge pos_rclk);
    chk("bp_hold_data1", out_data, 8'h11);
    chk("bp_hold_valid1", out_valid, 1);
    tick(); out_ready = 1'b1;
    wait_idle();
    chk("bp_pops", rd_pulses - pc0, 2);

    // Underrun: port 1 stalls 5 cycles after word 1, port 0 must wait
    sync_reset();
    nb = n_beats;
    put(1, 8'h20, 0, 0, 1);
    put(1, 8'h21, 0, 0, 1);
    put(1, 8'h22, 1, 1, 1);
    wait_beats(nb + 1);
    mask[1] = 1'b1;
    put(0, 8'h30, 1, 1, 1);
    uv = 1'b0; ub = 1'b1; pbad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge pos_rclk);
      uv |= out_valid;
      ub &= busy;
      if (out_port != 2'd1) pbad++;
    end
    chk("underrun_valid", uv, 0);
    chk("underrun_busy", ub, 1);
    chk("underrun_port", pbad, 0);
    tick(); mask[1] = 1'b0;
    wait_idle();

    // Watchdog: 6 words without EOP truncated at word 4, ptr moves to 1
    sync_reset();
    e0 = err_cnt;
    for (int k = 0; k < 4; k++) put(0, 8'h40 + 8'(k), 0, k == 3, 1);
    put(1, 8'h50, 1, 1, 1);
    put(0, 8'h44, 0, 0, 1);
    put(0, 8'h45, 0, 0, 1);
    put(0, 8'h46, 1, 1, 1);
    wait_idle();
    chk("wd_err_pulses", err_cnt - e0, 1);

    // Async reset mid-packet on word 2, then fresh arbitration from port 0
    nb = n_beats;
    put(2, 8'h60, 0, 0, 1);
    put(2, 8'h61, 0, 0, 1);
    put(2, 8'h62, 1, 1, 1);
    wait_beats(nb + 1);
    chk("pre_rst_valid", out_valid, 1);
    aresetn_rclk = 1'b0;
    #1;
    chk("arst_rd_en", fifo_rd_en, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_port", out_port, 0);
    sb.delete();
    put(0, 8'h70, 1, 1, 1);
    push_exp(2, 8'h61, 0);
    push_exp(2, 8'h62, 1);
    tick();
    aresetn_rclk = 1'b1;
    #1;
    chk("post_rst_busy", busy, 0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
